// File: rtl/spi_slave_ctrl_fsm.sv
// SPI-slave transaction sequencer: address / R-W / data framing with registered datapath strobes.
// Optional burst continuation (addr_inc, back-to-back frames) enabled by SPI_SLAVE_CTRL_BURST_EN.
module spi_slave_ctrl_fsm #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          CPOL       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sck,
  input  logic cs,
  input  logic mosi,
  output logic miso_en,
  output logic addr_we,
  output logic sr_we,
  output logic dm_we,
  output logic addr_inc,
  output logic busy,
  output logic abort
);

  localparam int unsigned MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(MAX_W + 1);
  localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    RW    = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4,
    DONE  = 3'd5
  } state_e;

  state_e           state_q,    state_d;
  logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
  logic             sck_prev_q, sck_prev_d;
  logic             miso_en_q,  miso_en_d;
  logic             addr_we_q,  addr_we_d;
  logic             sr_we_q,    sr_we_d;
  logic             dm_we_q,    dm_we_d;
  logic             busy_q,     busy_d;
  logic             abort_q,    abort_d;
  logic             sample_c;
  logic             cnt_zero_c;

`ifdef SPI_SLAVE_CTRL_BURST_EN
  logic addr_inc_q, addr_inc_d;
  // sr_we for the next burst frame is deferred one cycle behind addr_inc
  logic sr_pend_q,  sr_pend_d;
`endif

  assign sample_c   = (sck != sck_prev_q) && (sck == ~CPOL);
  assign cnt_zero_c = (bit_cnt_q == '0);

  // Next-state, counter and strobe decode
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sck_prev_d = sck;
    addr_we_d  = 1'b0;
    sr_we_d    = 1'b0;
    dm_we_d    = 1'b0;
    abort_d    = 1'b0;
`ifdef SPI_SLAVE_CTRL_BURST_EN
    addr_inc_d = 1'b0;
    sr_pend_d  = 1'b0;
`endif

    if (cs) begin
      state_d = IDLE;
`ifdef SPI_SLAVE_CTRL_BURST_EN
      // A clean frame boundary in burst mode is a normal end of transfer
      abort_d = (state_q == ADDR) || (state_q == RW) ||
                (((state_q == READ) || (state_q == WRITE)) && (bit_cnt_q != DATA_LAST));
`else
      abort_d = (state_q == ADDR) || (state_q == RW) ||
                (state_q == READ) || (state_q == WRITE);
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = ADDR;
          bit_cnt_d = ADDR_LAST;
        end
        ADDR: begin
          if (sample_c) begin
            if (cnt_zero_c) begin
              state_d   = RW;
              addr_we_d = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q - CNT_W'(1);
            end
          end
        end
        RW: begin
          if (sample_c) begin
            bit_cnt_d = DATA_LAST;
            if (mosi) begin
              state_d = READ;
              sr_we_d = 1'b1;
            end else begin
              state_d = WRITE;
            end
          end
        end
        READ: begin
`ifdef SPI_SLAVE_CTRL_BURST_EN
          sr_we_d = sr_pend_q;
`endif
          if (sample_c) begin
            if (cnt_zero_c) begin
`ifdef SPI_SLAVE_CTRL_BURST_EN
              addr_inc_d = 1'b1;
              sr_pend_d  = 1'b1;
              bit_cnt_d  = DATA_LAST;
`else
              state_d = DONE;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q - CNT_W'(1);
            end
          end
        end
        WRITE: begin
          if (sample_c) begin
            if (cnt_zero_c) begin
              dm_we_d = 1'b1;
`ifdef SPI_SLAVE_CTRL_BURST_EN
              addr_inc_d = 1'b1;
              bit_cnt_d  = DATA_LAST;
`else
              state_d = DONE;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q - CNT_W'(1);
            end
          end
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    miso_en_d = (state_d == READ);
    busy_d    = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      sck_prev_q <= CPOL;
      miso_en_q  <= 1'b0;
      addr_we_q  <= 1'b0;
      sr_we_q    <= 1'b0;
      dm_we_q    <= 1'b0;
      busy_q     <= 1'b0;
      abort_q    <= 1'b0;
`ifdef SPI_SLAVE_CTRL_BURST_EN
      addr_inc_q <= 1'b0;
      sr_pend_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      sck_prev_q <= sck_prev_d;
      miso_en_q  <= miso_en_d;
      addr_we_q  <= addr_we_d;
      sr_we_q    <= sr_we_d;
      dm_we_q    <= dm_we_d;
      busy_q     <= busy_d;
      abort_q    <= abort_d;
`ifdef SPI_SLAVE_CTRL_BURST_EN
      addr_inc_q <= addr_inc_d;
      sr_pend_q  <= sr_pend_d;
`endif
    end
  end

  assign miso_en = miso_en_q;
  assign addr_we = addr_we_q;
  assign sr_we   = sr_we_q;
  assign dm_we   = dm_we_q;
  assign busy    = busy_q;
  assign abort   = abort_q;
`ifdef SPI_SLAVE_CTRL_BURST_EN
  assign addr_inc = addr_inc_q;
`else
  assign addr_inc = 1'b0;
`endif

endmodule
